// File: rtl/tank_sprite_fetcher.sv
// Per-scanline sprite row fetcher: loads the tank's ROM row into a line buffer during hblank
// and streams 2-bit palette indices as the beam crosses the sprite.
module tank_sprite_fetcher #(
  parameter int ADDR_W      = 11,
  parameter int SPR_W       = 13,
  parameter int SPR_H       = 16,
  parameter int SPRITE_BASE = 0,
  parameter int ROM_LAT     = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 line_start,
  input  logic [9:0]           LineY,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           TankX,
  input  logic [9:0]           TankY,
  input  logic [1:0]           TankDir,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [2*SPR_W-1:0]   rom_data,
  output logic                 pix_valid,
  output logic [1:0]           pix_idx,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LAT - 1);

  logic [1:0]         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [ADDR_W-1:0]  addr_q,    addr_d;
  logic               busy_q,    busy_d;
  logic               row_hit_q, row_hit_d;
  logic [2*SPR_W-1:0] row_buf_q, row_buf_d;
  logic [9:0]         sx_q,      sx_d;
  logic               pix_valid_q, pix_valid_d;
  logic [1:0]         pix_idx_q,   pix_idx_d;

  logic [10:0]        row_s;
  logic               row_ok_s;
  logic [ADDR_W-1:0]  fetch_addr_s;
  logic [10:0]        col_s;
  logic               col_hit_s;
  logic [10:0]        shift_s;
  logic [1:0]         idx_s;

  // Row/column offsets are 11-bit differences so a negative offset shows up in bit 10 instead of wrapping
  always_comb begin
    row_s        = {1'b0, LineY} - {1'b0, TankY};
    row_ok_s     = (row_s[10] == 1'b0) && (row_s < 11'(SPR_H));
    fetch_addr_s = ADDR_W'(SPRITE_BASE) + ADDR_W'(TankDir) * ADDR_W'(SPR_H) + ADDR_W'(row_s);
    col_s        = {1'b0, DrawX} - {1'b0, sx_q};
    col_hit_s    = row_hit_q && (col_s[10] == 1'b0) && (col_s < 11'(SPR_W));
    if (col_hit_s) begin
      shift_s = 11'(2 * (SPR_W - 1)) - {col_s[9:0], 1'b0};
    end else begin
      shift_s = 11'd0;
    end
    idx_s = 2'(row_buf_q >> shift_s);
  end

  // Fetch FSM; a line_start in any state restarts the fetch with freshly captured shadows
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    row_hit_d = row_hit_q;
    row_buf_d = row_buf_q;
    sx_d      = sx_q;
    if (line_start) begin
      sx_d      = TankX;
      row_hit_d = 1'b0;
      cnt_d     = {CNT_W{1'b0}};
      if (row_ok_s) begin
        addr_d  = fetch_addr_s;
        busy_d  = 1'b1;
        state_d = ST_WAIT;
      end else begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_LOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LOAD: begin
          row_buf_d = rom_data;
          row_hit_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Pixel stage: index 0 is transparent, so it never raises pix_valid
  always_comb begin
    if (col_hit_s) begin
      pix_idx_d   = idx_s;
      pix_valid_d = (idx_s != 2'd0);
    end else begin
      pix_idx_d   = 2'd0;
      pix_valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      busy_q      <= 1'b0;
      row_hit_q   <= 1'b0;
      row_buf_q   <= {(2*SPR_W){1'b0}};
      sx_q        <= 10'd0;
      pix_valid_q <= 1'b0;
      pix_idx_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      row_hit_q   <= row_hit_d;
      row_buf_q   <= row_buf_d;
      sx_q        <= sx_d;
      pix_valid_q <= pix_valid_d;
      pix_idx_q   <= pix_idx_d;
    end
  end

  assign rom_addr  = addr_q;
  assign busy      = busy_q;
  assign pix_valid = pix_valid_q;
  assign pix_idx   = pix_idx_q;

endmodule

// File: tb/tb_tank_sprite_fetcher.sv
// Directed bench for tank_sprite_fetcher with a small synchronous ROM model (one cycle latency).
module tb_tank_sprite_fetcher;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        line_start;
  logic [9:0]  LineY, DrawX, TankX, TankY;
  logic [1:0]  TankDir;
  logic [10:0] rom_addr;
  logic [25:0] rom_data;
  logic        pix_valid;
  logic [1:0]  pix_idx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  tank_sprite_fetcher dut (
    .Clk(Clk), .Reset(Reset), .line_start(line_start), .LineY(LineY), .DrawX(DrawX),
    .TankX(TankX), .TankY(TankY), .TankDir(TankDir), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_idx(pix_idx), .busy(busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [25:0] rom_row(input logic [10:0] a);
    case (a)
      11'd0:   rom_row = 26'h0001000;
      11'd16:  rom_row = 26'h2AAAAAA;
      11'd35:  rom_row = 26'h3000002;
      11'd48:  rom_row = 26'h1555555;
      11'd49:  rom_row = 26'h3000000;
      default: rom_row = 26'h0000000;
    endcase
  endfunction

  always @(posedge Clk) rom_data <= rom_row(rom_addr);

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [9:0] ly);
    LineY = ly;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic pix(input logic [9:0] x, input logic ev, input logic [1:0] ei, input string tag);
    DrawX = x;
    tick();
    chk({tag, "_valid"}, {31'd0, pix_valid}, {31'd0, ev});
    chk({tag, "_idx"}, {30'd0, pix_idx}, {30'd0, ei});
  endtask

  initial begin
    Reset = 1'b0; line_start = 1'b0; LineY = 10'd0; DrawX = 10'd0;
    TankX = 10'd0; TankY = 10'd0; TankDir = 2'd0; rom_data = 26'd0;
    repeat (2) tick();
    chk("rst_addr", {21'd0, rom_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_idx", {30'd0, pix_idx}, 32'd0);
    Reset = 1'b1;
    tick();

    // dir 0, row 0: only column 6 is opaque (index 1)
    TankX = 10'd100; TankY = 10'd50; TankDir = 2'd0;
    pulse(10'd50);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_addr", {21'd0, rom_addr}, 32'd0);
    tick(); tick();
    chk("t1_done", {31'd0, busy}, 32'd0);
    pix(10'd106, 1'b1, 2'd1, "t1_col6");
    pix(10'd105, 1'b0, 2'd0, "t1_col5");

    // dir 2, row 3 -> address 35: col0 index 3, col12 index 2
    TankDir = 2'd2;
    pulse(10'd53);
    chk("t2_addr", {21'd0, rom_addr}, 32'd35);
    tick(); tick();
    pix(10'd100, 1'b1, 2'd3, "t2_col0");
    pix(10'd112, 1'b1, 2'd2, "t2_col12");
    pix(10'd113, 1'b0, 2'd0, "t2_col13");
    pix(10'd99,  1'b0, 2'd0, "t2_left");

    // row 16 is past the sprite: no fetch, and row_hit is dropped
    pulse(10'd66);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_addr", {21'd0, rom_addr}, 32'd35);
    pix(10'd100, 1'b0, 2'd0, "t3_nohit");
    pulse(10'd49);
    chk("t3_above_busy", {31'd0, busy}, 32'd0);

    // right-edge clipping with a fully opaque row (index 2 everywhere)
    TankX = 10'd635; TankY = 10'd100; TankDir = 2'd1;
    pulse(10'd100);
    chk("t4_addr", {21'd0, rom_addr}, 32'd16);
    tick(); tick();
    for (int x = 635; x <= 639; x++) pix(10'(x), 1'b1, 2'd2, "t4_edge");
    for (int x = 0; x <= 7; x++) pix(10'(x), 1'b0, 2'd0, "t4_nowrap");

    // back-to-back pulses: the second row (addr 49) must be the one loaded
    TankX = 10'd300; TankY = 10'd200; TankDir = 2'd3;
    LineY = 10'd200; line_start = 1'b1;
    tick();
    LineY = 10'd201;
    tick();
    line_start = 1'b0;
    chk("t5_addr", {21'd0, rom_addr}, 32'd49);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    tick(); tick();
    chk("t5_done", {31'd0, busy}, 32'd0);
    pix(10'd300, 1'b1, 2'd3, "t5_col0");
    pix(10'd301, 1'b0, 2'd0, "t5_col1");

    // mid-line motion must not disturb the current line
    TankX = 10'd0; TankDir = 2'd0;
    pix(10'd300, 1'b1, 2'd3, "t6_hold");
    pix(10'd6,   1'b0, 2'd0, "t6_newx");
    chk("t6_addr", {21'd0, rom_addr}, 32'd49);
    TankY = 10'd50;
    pulse(10'd50);
    chk("t6_new_addr", {21'd0, rom_addr}, 32'd0);
    tick(); tick();
    pix(10'd6, 1'b1, 2'd1, "t6_after");

    // asynchronous reset during a fetch clears everything immediately
    TankDir = 2'd2;
    pulse(10'd53);
    chk("t7_addr", {21'd0, rom_addr}, 32'd35);
    chk("t7_prev_valid", {31'd0, pix_valid}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("t7_busy", {31'd0, busy}, 32'd0);
    chk("t7_rom", {21'd0, rom_addr}, 32'd0);
    chk("t7_valid", {31'd0, pix_valid}, 32'd0);
    chk("t7_idx", {30'd0, pix_idx}, 32'd0);
    #1;
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) pix(10'd0, 1'b0, 2'd0, "t7_quiet");
    pulse(10'd53);
    tick(); tick();
    pix(10'd0, 1'b1, 2'd3, "t7_resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
